mul_pipeline: RTL and testbench
===============================

// Module: mul_pipeline
// PURPOSE
//  Five-stage (ex1..ex5) pipelined integer multiplier downstream of the decode
//  stage. Takes multiply instructions issued on the decode ex-valid path and
//  returns the low DATA_WIDTH bits of rs1*rs2 at ex5. Per-stage valid and
//  destination-register outputs feed decode hazard detection and ex5 bypass.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width; must be a multiple of 4
//  REGISTER_WIDTH 5   register-index width
// PORTS
//  clk_i          in   1               clock
//  rst_ni         in   1               async reset, active low
//  valid_i        in   1               multiply issued this cycle (decode ex_valid_o)
//  stall_i        in   1               downstream cannot accept; freeze pipeline
//  flush_i        in   1               kill all in-flight ops and this cycle's issue
//  rs1_data_i     in   DATA_WIDTH      operand A (bypassed)
//  rs2_data_i     in   DATA_WIDTH      operand B (bypassed)
//  wr_reg_i       in   REGISTER_WIDTH  destination register
//  exN_valid_o    out  1               stage N holds a live op (N=1..5)
//  exN_wr_reg_o   out  REGISTER_WIDTH  stage N destination register (N=1..5)
//  ex5_result_o   out  DATA_WIDTH      product low bits, meaningful when ex5_valid_o
//  busy_o         out  1               OR of ex1..ex5 valid
// BEHAVIOUR
//  - Reset: all valids 0, all wr_regs 0, operand/accumulator regs 0,
//    ex5_result_o 0. Reset asserted mid-operation discards all ops.
//  - Issue accepted when valid_i & ~stall_i & ~flush_i; op enters ex1 next edge.
//  - Latency: accepted at cycle N -> ex1 valid N+1 ... ex5 valid N+5.
//    Throughput one op/cycle; back-to-back issue needs no bubbles.
//  - Datapath, C = DATA_WIDTH/4, B_k = B[(k+1)*C-1 : k*C]:
//    ex1 latches A, B; ex2 acc = A*B_0; ex3 acc += (A*B_1)<<C;
//    ex4 acc += (A*B_2)<<2C; ex5 acc += (A*B_3)<<3C.
//    A and B travel with the op. All arithmetic is truncated to DATA_WIDTH
//    (wrap). Low bits are identical for signed and unsigned operands.
//  - ex5_result_o = ex5 accumulator, registered; no combinational input->output path.
//  - Bubbles: a stage with valid 0 still shifts when not stalled. Its wr_reg
//    and data are don't-care but must not cause X on outputs.
//  - stall_i=1: every stage register holds, including ex5. valid_i is ignored;
//    decode must hold the issue until stall_i drops.
//  - flush_i=1: all ex valids clear next edge; any issue this cycle is dropped.
//    Flush has priority over stall. Data regs may keep stale values.
//  - Op in ex5 with stall_i=0 retires at the edge. Ex5 valid may be 1 for
//    exactly one unstalled cycle per op.
// CONFIGURATION
//  MUL_PIPE_PERF_EN defined: adds outputs perf_retired_o[31:0] (+1 per op
//    leaving ex5 unstalled and unflushed) and perf_stall_o[31:0] (+1 per cycle
//    with stall_i & busy_o). Both reset to 0 and wrap at 2^32.
//  MUL_PIPE_PERF_EN undefined: these ports and counters do not exist; the
//    rest of the behaviour is identical.
// TESTING
//  1 issue 3*5 at cycle 0 -> ex1_valid at 1 ... ex5_valid at 5, result 15, wr_reg echoed
//  2 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; 0x80000000*2 -> 0x00000000;
//    0x12345678*0x9ABCDEF0 -> 0x242D2080
//  3 4 back-to-back issues (2*3, 4*5, 6*7, 8*9) -> ex5 results 6, 20, 42, 72
//    on consecutive cycles 5..8
//  4 stall_i high 2 cycles while op in ex3 -> all stages hold; result appears
//    at cycle 7, not 5; valid_i during stall not captured
//  5 flush_i with ops in ex1/ex3 plus same-cycle issue -> all valids 0 next
//    cycle, busy_o 0; flush+stall together -> still flushed
//  6 rst_ni low with ops in flight -> all outputs 0 immediately (async);
//    with MUL_PIPE_PERF_EN: 3 ops retired, 2 stall cycles -> counters 3, 2

Source files
------------

// File: rtl/mul_pipeline_if.sv
// Issue/result bundle between decode and the multiplier pipeline.
// Perf counter outputs exist only when MUL_PIPE_PERF_EN is defined.
interface mul_pipeline_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
);
    logic                      valid_i;
    logic                      stall_i;
    logic                      flush_i;
    logic [DATA_WIDTH-1:0]     rs1_data_i;
    logic [DATA_WIDTH-1:0]     rs2_data_i;
    logic [REGISTER_WIDTH-1:0] wr_reg_i;

    logic                      ex1_valid_o;
    logic                      ex2_valid_o;
    logic                      ex3_valid_o;
    logic                      ex4_valid_o;
    logic                      ex5_valid_o;
    logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o;
    logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o;
    logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o;
    logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o;
    logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o;
    logic [DATA_WIDTH-1:0]     ex5_result_o;
    logic                      busy_o;
`ifdef MUL_PIPE_PERF_EN
    logic [31:0]               perf_retired_o;
    logic [31:0]               perf_stall_o;
`endif

    modport slave (
        input  valid_i, stall_i, flush_i, rs1_data_i, rs2_data_i, wr_reg_i,
        output ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o,
        output ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o,
`ifdef MUL_PIPE_PERF_EN
        output perf_retired_o, perf_stall_o,
`endif
        output ex5_result_o, busy_o
    );

    modport master (
        output valid_i, stall_i, flush_i, rs1_data_i, rs2_data_i, wr_reg_i,
        input  ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o,
        input  ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o,
`ifdef MUL_PIPE_PERF_EN
        input  perf_retired_o, perf_stall_o,
`endif
        input  ex5_result_o, busy_o
    );
endinterface

// File: rtl/mul_pipeline.sv
// Five-stage multiplier: ex1 latches operands, ex2..ex5 each add one quarter-width partial product.
// Optional retire/stall counters are built when MUL_PIPE_PERF_EN is defined.
module mul_pipeline #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mul_pipeline_if.slave bus
);
    localparam int C = DATA_WIDTH / 4;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REGISTER_WIDTH-1:0] reg_t;

    logic [5:1] valid_q, valid_d;
    reg_t       wr_reg_q [1:5];
    reg_t       wr_reg_d [1:5];
    word_t      a_q [1:4];
    word_t      a_d [1:4];
    word_t      b_q [1:4];
    word_t      b_d [1:4];
    word_t      acc_q [2:5];
    word_t      acc_d [2:5];

    // A times the k-th C-bit slice of B, placed at its weight; wraps to DATA_WIDTH.
    function automatic word_t partial(input word_t a, input word_t b, input int k);
        word_t bk;
        bk        = '0;
        bk[C-1:0] = b[k*C +: C];
        return (a * bk) << (k * C);
    endfunction

    always_comb begin
        valid_d  = valid_q;
        wr_reg_d = wr_reg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        if (!bus.stall_i) begin
            valid_d[1]   = bus.valid_i;
            valid_d[5:2] = valid_q[4:1];
            wr_reg_d[1]  = bus.wr_reg_i;
            a_d[1]       = bus.rs1_data_i;
            b_d[1]       = bus.rs2_data_i;
            for (int s = 2; s <= 5; s++) wr_reg_d[s] = wr_reg_q[s-1];
            for (int s = 2; s <= 4; s++) begin
                a_d[s] = a_q[s-1];
                b_d[s] = b_q[s-1];
            end
            acc_d[2] = partial(a_q[1], b_q[1], 0);
            acc_d[3] = acc_q[2] + partial(a_q[2], b_q[2], 1);
            acc_d[4] = acc_q[3] + partial(a_q[3], b_q[3], 2);
            acc_d[5] = acc_q[4] + partial(a_q[4], b_q[4], 3);
        end
        // Flush wins over stall and also drops this cycle's issue.
        if (bus.flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int s = 1; s <= 5; s++) wr_reg_q[s] <= '0;
            for (int s = 1; s <= 4; s++) begin
                a_q[s] <= '0;
                b_q[s] <= '0;
            end
            for (int s = 2; s <= 5; s++) acc_q[s] <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_reg_q <= wr_reg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
        end
    end

    assign bus.ex1_valid_o  = valid_q[1];
    assign bus.ex2_valid_o  = valid_q[2];
    assign bus.ex3_valid_o  = valid_q[3];
    assign bus.ex4_valid_o  = valid_q[4];
    assign bus.ex5_valid_o  = valid_q[5];
    assign bus.ex1_wr_reg_o = wr_reg_q[1];
    assign bus.ex2_wr_reg_o = wr_reg_q[2];
    assign bus.ex3_wr_reg_o = wr_reg_q[3];
    assign bus.ex4_wr_reg_o = wr_reg_q[4];
    assign bus.ex5_wr_reg_o = wr_reg_q[5];
    assign bus.ex5_result_o = acc_q[5];
    assign bus.busy_o       = |valid_q;

`ifdef MUL_PIPE_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        retired_d   = retired_q + 32'(valid_q[5] & ~bus.stall_i & ~bus.flush_i);
        stall_cnt_d = stall_cnt_q + 32'(bus.stall_i & (|valid_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            retired_q   <= retired_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_retired_o = retired_q;
    assign bus.perf_stall_o   = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mul_pipeline.sv
// Directed bench for mul_pipeline: vector table for products, hand sequences for
// latency, back-to-back, stall, flush and async reset (plus counters with MUL_PIPE_PERF_EN).
module tb_mul_pipeline;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_pipeline_if #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) bus ();
    mul_pipeline #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
        bus.valid_i    = v;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        bus.wr_reg_i   = r;
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
    endtask

    function automatic logic [4:0] valids();
        return {bus.ex5_valid_o, bus.ex4_valid_o, bus.ex3_valid_o,
                bus.ex2_valid_o, bus.ex1_valid_o};
    endfunction

    function automatic logic [24:0] wr_regs();
        return {bus.ex5_wr_reg_o, bus.ex4_wr_reg_o, bus.ex3_wr_reg_o,
                bus.ex2_wr_reg_o, bus.ex1_wr_reg_o};
    endfunction

    vec_t vecs [7];
    vec_t b2b  [4];

    initial begin
        vecs[0] = '{32'd3,        32'd5,        32'd15};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[2] = '{32'h80000000, 32'd2,        32'h00000000};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h242D2080};
        vecs[4] = '{32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'h00000000};
        vecs[6] = '{32'd0,        32'h12345678, 32'h00000000};
        b2b[0]  = '{32'd2, 32'd3, 32'd6};
        b2b[1]  = '{32'd4, 32'd5, 32'd20};
        b2b[2]  = '{32'd6, 32'd7, 32'd42};
        b2b[3]  = '{32'd8, 32'd9, 32'd72};

        idle();
        drive(1'b0, 32'd0, 32'd0, 5'd0);
        #12;
        check("reset valids", 64'(valids()), 64'd0);
        check("reset wr_regs", 64'(wr_regs()), 64'd0);
        check("reset result", 64'(bus.ex5_result_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        rst_n = 1'b1;
        step();

        // Single op latency: one-hot valid walks ex1..ex5
        drive(1'b1, 32'd3, 32'd5, 5'd7);
        for (int c = 1; c <= 5; c++) begin
            step();
            idle();
            check($sformatf("lat valids c%0d", c), 64'(valids()), 64'(5'b1 << (c - 1)));
        end
        check("lat ex1_wr_reg path", 64'(bus.ex5_wr_reg_o), 64'd7);
        check("lat result", 64'(bus.ex5_result_o), 64'd15);
        check("lat busy", 64'(bus.busy_o), 64'd1);
        step();
        check("lat retired busy", 64'(bus.busy_o), 64'd0);

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, 5'(i + 1));
            step();
            idle();
            repeat (4) step();
            check($sformatf("vec%0d ex5_valid", i), 64'(bus.ex5_valid_o), 64'd1);
            check($sformatf("vec%0d result", i), 64'(bus.ex5_result_o), 64'(vecs[i].exp));
            check($sformatf("vec%0d wr_reg", i), 64'(bus.ex5_wr_reg_o), 64'(i + 1));
            step();
        end

        // Back-to-back issue, results on consecutive cycles 5..8
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, b2b[i].a, b2b[i].b, 5'(i + 1));
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("b2b%0d ex5_valid", i), 64'(bus.ex5_valid_o), 64'd1);
            check($sformatf("b2b%0d result", i), 64'(bus.ex5_result_o), 64'(b2b[i].exp));
            check($sformatf("b2b%0d wr_reg", i), 64'(bus.ex5_wr_reg_o), 64'(i + 1));
        end
        step();
        check("b2b drained", 64'(valids()), 64'd0);

        // Stall two cycles with the op in ex3
        drive(1'b1, 32'd7, 32'd6, 5'd9);
        step();
        idle();
        step();
        step();
        check("stall pre ex3", 64'(valids()), 64'b00100);
        bus.stall_i = 1'b1;
        drive(1'b1, 32'd1, 32'd1, 5'd3);
        step();
        check("stall c4 hold", 64'(valids()), 64'b00100);
        step();
        idle();
        check("stall c5 hold", 64'(valids()), 64'b00100);
        check("stall c5 no ex5", 64'(bus.ex5_valid_o), 64'd0);
        step();
        check("stall c6", 64'(valids()), 64'b01000);
        step();
        check("stall c7 valids", 64'(valids()), 64'b10000);
        check("stall c7 result", 64'(bus.ex5_result_o), 64'd42);
        check("stall c7 wr_reg", 64'(bus.ex5_wr_reg_o), 64'd9);
        step();
        check("stall drained", 64'(bus.busy_o), 64'd0);

        // Flush with ops in ex1 and ex3 plus a same-cycle issue
        drive(1'b1, 32'd2, 32'd2, 5'd1);
        step();
        idle();
        step();
        drive(1'b1, 32'd3, 32'd3, 5'd2);
        step();
        idle();
        check("flush pre", 64'(valids()), 64'b00101);
        bus.flush_i = 1'b1;
        drive(1'b1, 32'd4, 32'd4, 5'd3);
        step();
        idle();
        check("flush valids", 64'(valids()), 64'd0);
        check("flush busy", 64'(bus.busy_o), 64'd0);

        // Flush and stall together
        drive(1'b1, 32'd5, 32'd5, 5'd4);
        step();
        idle();
        step();
        check("flush+stall pre", 64'(valids()), 64'b00010);
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        drive(1'b1, 32'd6, 32'd6, 5'd5);
        step();
        idle();
        check("flush+stall valids", 64'(valids()), 64'd0);
        check("flush+stall busy", 64'(bus.busy_o), 64'd0);
        step();

        // Async reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b2b[i].a, b2b[i].b, 5'(i + 10));
            step();
        end
        idle();
        step();
        step();
        check("rst pre ex5", 64'(bus.ex5_valid_o), 64'd1);
        check("rst pre result", 64'(bus.ex5_result_o), 64'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async valids", 64'(valids()), 64'd0);
        check("rst async wr_regs", 64'(wr_regs()), 64'd0);
        check("rst async result", 64'(bus.ex5_result_o), 64'd0);
        check("rst async busy", 64'(bus.busy_o), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst stays empty", 64'(valids()), 64'd0);

`ifdef MUL_PIPE_PERF_EN
        check("perf reset retired", 64'(bus.perf_retired_o), 64'd0);
        check("perf reset stall", 64'(bus.perf_stall_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b2b[i].a, b2b[i].b, 5'(i + 1));
            step();
        end
        idle();
        bus.stall_i = 1'b1;
        step();
        step();
        bus.stall_i = 1'b0;
        repeat (8) step();
        check("perf retired", 64'(bus.perf_retired_o), 64'd3);
        check("perf stall", 64'(bus.perf_stall_o), 64'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
